// File: rtl/sprite_command_decoder.sv
// Command front end for the sprite position finder: a small command FIFO feeding a
// decoder FSM that strobes the finder's function bus and collects collision answers.
module sprite_command_decoder #(
    parameter int FIFO_DEPTH       = 4,
    parameter int HOLD_CYCLES      = 4,
    parameter int COLISION_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_data,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        active_function_processor,
    output logic [1:0]  function_selector,
    output logic [5:0]  function_id_sprit,
    output logic [9:0]  function_col,
    output logic [9:0]  function_row,
    output logic [5:0]  function_input01,
    output logic [5:0]  function_input02,
    input  logic        function_sp_colision_out,
    output logic        colision_valid,
    output logic        colision_result,
    output logic        err_opcode,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (COLISION_TIMEOUT > 1) ? $clog2(COLISION_TIMEOUT) : 1;

    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(COLISION_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_WAIT_COL = 3'd4;

    localparam logic [1:0] OP_COL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Only bits [31:4] of a command carry information, so only those are stored.
    logic [27:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    logic [2:0]    state;
    logic [27:0]   cmd;
    logic [1:0]    cmd_op;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] timer;
    logic          col_fire;
    logic          col_result_q;
    logic          load_fields;
    logic          unused_low_bits;

    assign unused_low_bits = ^instr_data[3:0];

    // instr handshake: a word transfers on any rising edge where instr_valid and
    // instr_ready are both high; instr_ready depends only on FIFO occupancy.
    assign instr_ready = (count < DEPTH_C);
    assign push        = instr_valid && instr_ready;
    assign pop         = (state == S_IDLE) && (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= instr_data[31:4];
    end

    assign cmd_op      = cmd[27:26];
    assign col_fire    = (state == S_WAIT_COL) &&
                         (function_sp_colision_out || (timer == TIMEOUT_LAST));
    assign load_fields = (state == S_DECODE) && (cmd_op != OP_RSV);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cmd          <= '0;
            hold_cnt     <= '0;
            timer        <= '0;
            col_result_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cmd   <= fifo_mem[rd_ptr];
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= (cmd_op == OP_RSV) ? S_IDLE : S_ISSUE;
                end
                S_ISSUE: begin
                    hold_cnt <= HOLD_LAST;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_cnt == '0) begin
                        timer <= '0;
                        state <= (cmd_op == OP_COL) ? S_WAIT_COL : S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_WAIT_COL: begin
                    // A flag arriving on the timeout cycle still counts as a hit.
                    if (col_fire) begin
                        col_result_q <= function_sp_colision_out;
                        state        <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            function_selector <= '0;
            function_id_sprit <= '0;
            function_col      <= '0;
            function_row      <= '0;
            function_input01  <= '0;
            function_input02  <= '0;
        end else if (load_fields) begin
            function_selector <= cmd_op;
            function_id_sprit <= cmd[25:20];
            if (cmd_op == OP_COL) begin
                function_col     <= '0;
                function_row     <= '0;
                function_input01 <= cmd[19:14];
                function_input02 <= cmd[13:8];
            end else begin
                function_col     <= cmd[19:10];
                function_row     <= cmd[9:0];
                function_input01 <= '0;
                function_input02 <= '0;
            end
        end
    end

    assign active_function_processor = (state == S_ISSUE);
    assign err_opcode                = (state == S_DECODE) && (cmd_op == OP_RSV);
    assign colision_valid            = col_fire;
    assign colision_result           = col_fire ? function_sp_colision_out : col_result_q;
    assign busy                      = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_sprite_command_decoder.sv
// Bench for sprite_command_decoder: a timeline model predicts every output per cycle
// from each command's acceptance time, plus an in-order issue scoreboard.
module tb_sprite_command_decoder;
  localparam int FIFO_DEPTH       = 4;
  localparam int HOLD_CYCLES      = 4;
  localparam int COLISION_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        instr_ready;
  logic        active_function_processor;
  logic [1:0]  function_selector;
  logic [5:0]  function_id_sprit;
  logic [9:0]  function_col;
  logic [9:0]  function_row;
  logic [5:0]  function_input01;
  logic [5:0]  function_input02;
  logic        function_sp_colision_out;
  logic        colision_valid;
  logic        colision_result;
  logic        err_opcode;
  logic        busy;

  sprite_command_decoder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .HOLD_CYCLES(HOLD_CYCLES),
    .COLISION_TIMEOUT(COLISION_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr_data(instr_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .active_function_processor(active_function_processor),
    .function_selector(function_selector),
    .function_id_sprit(function_id_sprit),
    .function_col(function_col),
    .function_row(function_row),
    .function_input01(function_input01),
    .function_input02(function_input02),
    .function_sp_colision_out(function_sp_colision_out),
    .colision_valid(colision_valid),
    .colision_result(colision_result),
    .err_opcode(err_opcode),
    .busy(busy)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // delay: cycles after entering WAIT_COL at which the finder raises its flag
  // (>= COLISION_TIMEOUT means the flag never comes).
  typedef struct {
    logic [31:0] data;
    int          delay;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    int          delay;
    int          acc;
    int          pop;
    int          strobe;
    int          wstart;
    int          done;
    int          idle_from;
    bit          hit;
  } cmd_t;

  pend_t       pend_q[$];
  cmd_t        cmds[$];
  logic [31:0] exp_q[$];

  int cyc       = 0;
  int checks    = 0;
  int failures  = 0;
  int last_idle = 0;
  int gap_pct   = 0;
  bit in_reset  = 1'b1;
  bit presenting = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [39:0] decode(input logic [31:0] w);
    logic [1:0] op;
    op = w[31:30];
    if (op == 2'b10) return {op, w[29:24], 10'd0, 10'd0, w[23:18], w[17:12]};
    return {op, w[29:24], w[23:14], w[13:4], 6'd0, 6'd0};
  endfunction

  function automatic int exp_count(input int c);
    int n = 0;
    foreach (cmds[i]) begin
      if (cmds[i].acc < c) n++;
      if (cmds[i].pop < c) n--;
    end
    return n;
  endfunction

  function automatic bit model_busy(input int c);
    foreach (cmds[i]) if (cmds[i].idle_from > c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic flag_for(input int c);
    foreach (cmds[i])
      if (cmds[i].data[31:30] == 2'b10 && cmds[i].wstart <= c && c <= cmds[i].done)
        return (c >= cmds[i].wstart + cmds[i].delay);
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: schedule of one accepted command, derived from when the decoder is next idle
  task automatic accept(input pend_t pw, input int c);
    cmd_t k;
    k.data   = pw.data;
    k.delay  = pw.delay;
    k.acc    = c;
    k.pop    = (c + 1 > last_idle) ? c + 1 : last_idle;
    k.strobe = -1;
    k.wstart = -1;
    k.done   = -1;
    k.hit    = 1'b0;
    case (pw.data[31:30])
      2'b11: k.idle_from = k.pop + 2;
      2'b10: begin
        k.strobe = k.pop + 2;
        k.wstart = k.strobe + HOLD_CYCLES + 1;
        if (pw.delay < COLISION_TIMEOUT) begin
          k.done = k.wstart + pw.delay;
          k.hit  = 1'b1;
        end else begin
          k.done = k.wstart + COLISION_TIMEOUT - 1;
        end
        k.idle_from = k.done + 1;
      end
      default: begin
        k.strobe    = k.pop + 2;
        k.idle_from = k.strobe + HOLD_CYCLES + 1;
      end
    endcase
    last_idle = k.idle_from;
    cmds.push_back(k);
    if (pw.data[31:30] != 2'b11) exp_q.push_back(pw.data);
  endtask

  task automatic check_outputs(input int c);
    int          n;
    logic        e_busy, e_strobe, e_err, e_cv, e_res;
    logic [39:0] e_f;
    logic [39:0] obs_f;
    logic [31:0] w;
    n        = exp_count(c);
    e_busy   = (n > 0);
    e_strobe = 1'b0;
    e_err    = 1'b0;
    e_cv     = 1'b0;
    e_res    = 1'b0;
    e_f      = '0;
    foreach (cmds[i]) begin
      if (cmds[i].pop < c && c < cmds[i].idle_from) e_busy = 1'b1;
      if (cmds[i].data[31:30] == 2'b11) begin
        if (cmds[i].pop + 1 == c) e_err = 1'b1;
      end else if (cmds[i].strobe <= c) begin
        e_f = decode(cmds[i].data);
        if (cmds[i].strobe == c) e_strobe = 1'b1;
      end
      if (cmds[i].data[31:30] == 2'b10 && cmds[i].done <= c) begin
        e_res = cmds[i].hit;
        e_cv  = (cmds[i].done == c);
      end
    end
    obs_f = {function_selector, function_id_sprit, function_col, function_row,
             function_input01, function_input02};
    check("instr_ready", 64'(instr_ready), 64'(n < FIFO_DEPTH));
    check("busy", 64'(busy), 64'(e_busy));
    check("strobe", 64'(active_function_processor), 64'(e_strobe));
    check("err_opcode", 64'(err_opcode), 64'(e_err));
    check("colision_valid", 64'(colision_valid), 64'(e_cv));
    check("colision_result", 64'(colision_result), 64'(e_res));
    check("fields", 64'(obs_f), 64'(e_f));
    // scoreboard: every strobe must carry the next accepted command, in order
    if (active_function_processor === 1'b1) begin
      check("issue_unexpected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("issue_order", 64'(obs_f), 64'(decode(w)));
      end
    end
  endtask

  task automatic tick();
    if (in_reset || pend_q.size() == 0) presenting = 1'b0;
    else if (!presenting) presenting = ($urandom_range(0, 99) >= gap_pct);
    instr_valid = presenting;
    instr_data  = presenting ? pend_q[0].data : $urandom();
    function_sp_colision_out = flag_for(cyc);
    @(negedge clk);
    check_outputs(cyc);
    if (presenting && exp_count(cyc) < FIFO_DEPTH) begin
      accept(pend_q.pop_front(), cyc);
      presenting = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] w, input int delay);
    pend_t p;
    p.data  = w;
    p.delay = delay;
    pend_q.push_back(p);
  endtask

  function automatic logic [31:0] mk_pos(input logic [1:0] op, input logic [5:0] id,
                                         input logic [9:0] col, input logic [9:0] row);
    return {op, id, col, row, 4'($urandom())};
  endfunction

  function automatic logic [31:0] mk_col(input logic [5:0] id, input logic [5:0] in1,
                                         input logic [5:0] in2);
    return {2'b10, id, in1, in2, 12'($urandom())};
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((pend_q.size() > 0 || model_busy(cyc)) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL %s_budget cycle=%0d observed=%0d expected<%0d", tag, cyc, n, budget);
    end
    repeat (2) tick();
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b0;
    in_reset = 1'b1;
    cmds.delete();
    pend_q.delete();
    exp_q.delete();
    presenting = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
    in_reset = 1'b0;
    last_idle = cyc;
  endtask

  initial begin
    int n;
    logic [1:0] op;
    rst = 1'b0;
    instr_valid = 1'b0;
    instr_data = '0;
    function_sp_colision_out = 1'b0;
    @(posedge clk);
    #1;
    apply_reset(3);
    repeat (3) tick();

    // T2: position command, op01 id5 col200 row50
    push(mk_pos(2'b01, 6'd5, 10'd200, 10'd50), 0);
    run_until_idle("pos", 60);

    // T3: collision hit, flag two cycles into WAIT_COL
    push(mk_col(6'd0, 6'd3, 6'd7), 2);
    run_until_idle("col_hit", 80);

    // T4: collision timeout, flag never raised
    push(mk_col(6'd0, 6'd3, 6'd7), 1000);
    run_until_idle("col_timeout", 80);

    // flag on the very first WAIT_COL cycle, and flag coinciding with timeout
    push(mk_col(6'd63, 6'd63, 6'd1), 0);
    push(mk_col(6'd17, 6'd0, 6'd63), COLISION_TIMEOUT - 1);
    push(mk_col(6'd18, 6'd9, 6'd10), COLISION_TIMEOUT);
    run_until_idle("col_edges", 120);

    // T5: six words back to back against a four-entry FIFO
    gap_pct = 0;
    for (int i = 0; i < 6; i++)
      push(mk_pos(2'(i & 1), 6'(i + 20), 10'($urandom()), 10'($urandom())), 0);
    run_until_idle("backpressure", 200);

    // T6: reserved opcode followed by op00 id9
    push({2'b11, 30'($urandom())}, 0);
    push(mk_pos(2'b00, 6'd9, 10'd1023, 10'd0), 0);
    run_until_idle("reserved", 60);

    // T1: reset while the first command is in HOLD and three more are queued
    for (int i = 0; i < 4; i++)
      push(mk_pos(2'b01, 6'(i + 40), 10'($urandom()), 10'($urandom())), 0);
    n = 0;
    while (!(cmds.size() > 0 && cyc >= cmds[0].strobe + 2) && n < 40) begin
      tick();
      n++;
    end
    check("reset_reach_hold", 64'(n < 40), 64'd1);
    apply_reset(3);
    repeat (20) tick();

    // randomized mix with gaps and random finder response times
    gap_pct = 30;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 9);
      op = (n < 3) ? 2'b00 : (n < 6) ? 2'b01 : (n < 9) ? 2'b10 : 2'b11;
      if (op == 2'b10)
        push(mk_col(6'($urandom()), 6'($urandom()), 6'($urandom())),
             $urandom_range(0, COLISION_TIMEOUT + 2));
      else
        push(mk_pos(op, 6'($urandom()), 10'($urandom()), 10'($urandom())), 0);
    end
    run_until_idle("random", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
